// File: rtl/spc3_pkg.sv
// Shared types and constants for the spc3 serial configuration bank.
package spc3_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } spc3_state_e;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_PAR  = 2'b01;
   localparam logic [1:0] ERR_STOP = 2'b10;
   localparam logic [1:0] ERR_ADDR = 2'b11;

   // spc2 field layout of a 16-bit channel word
   localparam int F_MSB  = 15;
   localparam int F_LSB  = 12;
   localparam int IQ_BIT = 11;
   localparam int GS_MSB = 10;
   localparam int GS_LSB = 7;
   localparam int CE_BIT = 6;
   localparam int NS_BIT = 5;
   localparam int GD_MSB = 4;
   localparam int GD_LSB = 2;
   localparam int FS_BIT = 1;
   localparam int RE_BIT = 0;

endpackage

// File: rtl/spc3_frame_rx.sv
// Serial frame receiver: start, address, data, even parity, stop.
// Produces a write strobe on the stop-sample edge and registered done/error pulses.
module spc3_frame_rx
   import spc3_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int ADDR_W = 2,
   parameter int CFG_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cfg_in_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [CFG_W-1:0]  wr_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_pulse_o,
   output logic [1:0]        err_code_o
);

   localparam int MAXW  = (ADDR_W > CFG_W) ? ADDR_W : CFG_W;
   localparam int CNT_W = $clog2(MAXW) + 1;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);

   spc3_state_e        state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CFG_W-1:0]   data_q;
   logic               par_q;
   logic               busy_q, done_q, err_q;
   logic [1:0]         err_code_q;

   logic [ADDR_W:0]    addr_shift;
   logic [CFG_W:0]     data_shift;
   logic [1:0]         err_code_d;
   logic               frame_bad;

   assign addr_shift = {addr_q, cfg_in_i};
   assign data_shift = {data_q, cfg_in_i};

   // Evaluated against the live stop bit while in STOP; stop > parity > address
   always_comb begin
      err_code_d = ERR_NONE;
      if (cfg_in_i)
         err_code_d = ERR_STOP;
      else if (par_q != ^{addr_q, data_q})
         err_code_d = ERR_PAR;
      else if (32'(addr_q) >= NCH)
         err_code_d = ERR_ADDR;
   end

   assign frame_bad = (err_code_d != ERR_NONE);
   assign wr_en_o   = (state_q == STOP) && !frame_bad;
   assign wr_addr_o = addr_q;
   assign wr_data_o = data_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_in_i) begin
                  state_q <= ADDR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ADDR: begin
               addr_q <= addr_shift[ADDR_W-1:0];
               if (cnt_q == ADDR_LAST) begin
                  cnt_q   <= '0;
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               data_q <= data_shift[CFG_W-1:0];
               if (cnt_q == DATA_LAST) begin
                  cnt_q   <= '0;
                  state_q <= PARITY;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               par_q   <= cfg_in_i;
               state_q <= STOP;
            end
            STOP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (frame_bad) begin
                  err_q      <= 1'b1;
                  err_code_q <= err_code_d;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_pulse_o = err_q;
   assign err_code_o  = err_code_q;

endmodule

// File: rtl/spc3_cfg_bank.sv
// Multi-channel configuration bank: serial frames load shadow words,
// a global apply copies every shadow to the active outputs in one edge.
module spc3_cfg_bank
   import spc3_pkg::*;
#(
   parameter int               NCH       = 4,
   parameter int               ADDR_W    = 2,
   parameter int               CFG_W     = 16,
   parameter logic [CFG_W-1:0] RESET_VAL = '0
) (
   input  logic                 Clk,
   input  logic                 Resetn,
   input  logic                 Cfg_in,
   input  logic                 Cfg_apply,
   output logic [NCH*CFG_W-1:0] Cfg_q,
   output logic                 Cfg_busy,
   output logic                 Cfg_done,
   output logic                 Cfg_err,
   output logic [1:0]           Err_code
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [CFG_W-1:0]  wr_data;

   logic [CFG_W-1:0]  shadow_q [NCH];
   logic [CFG_W-1:0]  shadow_d [NCH];
   logic [CFG_W-1:0]  active_q [NCH];
   logic [CFG_W-1:0]  active_d [NCH];

   spc3_frame_rx #(
      .NCH    (NCH),
      .ADDR_W (ADDR_W),
      .CFG_W  (CFG_W)
   ) u_rx (
      .clk_i       (Clk),
      .rst_n_i     (Resetn),
      .cfg_in_i    (Cfg_in),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .busy_o      (Cfg_busy),
      .done_o      (Cfg_done),
      .err_pulse_o (Cfg_err),
      .err_code_o  (Err_code)
   );

   // Apply reads shadow_q, so a same-edge write is only seen by a later apply
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         shadow_d[k] = shadow_q[k];
         active_d[k] = active_q[k];
         if (wr_en && (32'(wr_addr) == k))
            shadow_d[k] = wr_data;
         if (Cfg_apply)
            active_d[k] = shadow_q[k];
      end
   end

   always_ff @(posedge Clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (!Resetn) begin
            shadow_q[k] <= RESET_VAL;
            active_q[k] <= RESET_VAL;
         end else begin
            shadow_q[k] <= shadow_d[k];
            active_q[k] <= active_d[k];
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign Cfg_q[g*CFG_W +: CFG_W] = active_q[g];
   end

endmodule

// File: tb/tb_spc3_cfg_bank.sv
// Directed bench for spc3_cfg_bank: stimulus queues expected done/error events,
// an independent monitor pops them whenever the DUT pulses Cfg_done or Cfg_err.
module tb_spc3_cfg_bank;

   logic        Clk = 1'b0;
   logic        Resetn;
   logic        Cfg_in;
   logic        Cfg_apply;
   logic [63:0] Cfg_q;
   logic        Cfg_busy;
   logic        Cfg_done;
   logic        Cfg_err;
   logic [1:0]  Err_code;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [3:0]  exp_q [$];   // {done, err, code}

   spc3_cfg_bank #(
      .NCH       (4),
      .ADDR_W    (2),
      .CFG_W     (16),
      .RESET_VAL (16'h0000)
   ) dut (
      .Clk       (Clk),
      .Resetn    (Resetn),
      .Cfg_in    (Cfg_in),
      .Cfg_apply (Cfg_apply),
      .Cfg_q     (Cfg_q),
      .Cfg_busy  (Cfg_busy),
      .Cfg_done  (Cfg_done),
      .Cfg_err   (Cfg_err),
      .Err_code  (Err_code)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic par_of(input logic [1:0] a, input logic [15:0] d);
      return ^{a, d};
   endfunction

   // One frame, MSB first, one bit per negedge; optional apply on the stop bit
   task automatic send_frame(input logic [1:0] a, input logic [15:0] d, input logic bad_par,
                             input logic stop_bit, input logic apply_at_stop);
      logic [20:0] fr;
      fr = {1'b1, a, d, par_of(a, d) ^ bad_par, stop_bit};
      for (int i = 20; i >= 0; i--) begin
         @(negedge Clk);
         Cfg_in    = fr[i];
         Cfg_apply = (i == 0) ? apply_at_stop : 1'b0;
         if (i == 19) check("busy_in_frame", {63'd0, Cfg_busy}, 64'd1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         Cfg_in    = 1'b0;
         Cfg_apply = 1'b0;
      end
   endtask

   task automatic apply_pulse();
      @(negedge Clk);
      Cfg_apply = 1'b1;
      @(negedge Clk);
      Cfg_apply = 1'b0;
   endtask

   // Monitor: every done/err pulse must match the next queued expectation
   initial begin
      forever begin
         @(negedge Clk);
         if (Cfg_done || Cfg_err) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL unexpected_pulse: got done=%0b err=%0b code=%b, none expected",
                        Cfg_done, Cfg_err, Err_code);
            end else begin
               logic [3:0] e, a;
               e = exp_q.pop_front();
               a = {Cfg_done, Cfg_err, Cfg_err ? Err_code : 2'b00};
               if (a !== e) begin
                  n_miss++;
                  $display("FAIL frame_result: got {done,err,code}=%b expected %b", a, e);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      Resetn    = 1'b0;
      Cfg_in    = 1'b0;
      Cfg_apply = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_cfg_q",    Cfg_q, 64'h0);
      check("rst_flags",    {60'd0, Cfg_busy, Cfg_done, Cfg_err, 1'b0}, 64'h0);
      check("rst_err_code", {62'd0, Err_code}, 64'h0);
      Resetn = 1'b1;
      idle(2);

      // Good frame to ch2: shadow only until apply
      exp_q.push_back(4'b1000);
      send_frame(2'd2, 16'hA5C3, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("busy_idle", {63'd0, Cfg_busy}, 64'd0);
      check("good_no_apply", Cfg_q, 64'h0);
      apply_pulse();
      check("good_applied", Cfg_q, 64'h0000_A5C3_0000_0000);

      // Parity errors: same frame, then one that would change ch2
      exp_q.push_back(4'b0101);
      send_frame(2'd2, 16'hA5C3, 1'b1, 1'b0, 1'b0);
      idle(3);
      check("par_err_code", {62'd0, Err_code}, 64'h1);
      exp_q.push_back(4'b0101);
      send_frame(2'd2, 16'h1111, 1'b1, 1'b0, 1'b0);
      idle(3);
      apply_pulse();
      check("par_no_write", Cfg_q, 64'h0000_A5C3_0000_0000);

      // Stop error outranks parity error
      exp_q.push_back(4'b0110);
      send_frame(2'd1, 16'h5555, 1'b1, 1'b1, 1'b0);
      idle(3);
      check("stop_err_code", {62'd0, Err_code}, 64'h2);
      apply_pulse();
      check("stop_no_write", Cfg_q, 64'h0000_A5C3_0000_0000);

      // Back-to-back frames with zero gap
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b1000);
      send_frame(2'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
      send_frame(2'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      idle(3);
      check("err_code_holds", {62'd0, Err_code}, 64'h2);
      apply_pulse();
      check("b2b_applied", Cfg_q, 64'hFFFF_A5C3_0000_1234);

      // Apply on the stop-sample edge sees the pre-write shadow
      exp_q.push_back(4'b1000);
      send_frame(2'd1, 16'h0F0F, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("apply_at_stop", Cfg_q, 64'hFFFF_A5C3_0000_1234);
      apply_pulse();
      check("apply_after", Cfg_q, 64'hFFFF_A5C3_0F0F_1234);

      // Reset in the middle of the data field
      begin
         logic [7:0] part;
         part = {1'b1, 2'b01, 5'b10110};
         for (int i = 7; i >= 0; i--) begin
            @(negedge Clk);
            Cfg_in = part[i];
         end
      end
      @(negedge Clk);
      Resetn = 1'b0;
      Cfg_in = 1'b0;
      @(negedge Clk);
      check("midrst_cfg_q", Cfg_q, 64'h0);
      check("midrst_busy",  {63'd0, Cfg_busy}, 64'd0);
      check("midrst_code",  {62'd0, Err_code}, 64'h0);
      Resetn = 1'b1;
      idle(3);
      apply_pulse();
      check("midrst_shadow", Cfg_q, 64'h0);

      // Recovery after reset
      exp_q.push_back(4'b1000);
      send_frame(2'd3, 16'h8001, 1'b0, 1'b0, 1'b0);
      idle(3);
      apply_pulse();
      check("recover", Cfg_q, 64'h8001_0000_0000_0000);

      idle(4);
      check("events_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
